key_expansion_ctrl: RTL and testbench

Sequencer for the KeyExpansion round-key register file (64 x 32-bit words, 6-bit read select). On start it loads the cipher key words, then generates the remaining AES-128/192/256 schedule words at one word per cycle, using the file's single combinational read port for w[i-Nk]. When idle, it hands the read select to the cipher datapath through a simple grant.

---
 rtl/aes_ks_pkg.sv | 52 +++++
 rtl/ks_temp_gen.sv | 24 ++
 rtl/key_expansion_ctrl.sv | 131 +++++++++++++
 tb/tb_key_expansion_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ks_pkg.sv
// Shared encodings, constants and helpers for the AES key-schedule sequencer.
package aes_ks_pkg;

    typedef enum logic [1:0] {
        KeyLen128 = 2'd0,
        KeyLen192 = 2'd1,
        KeyLen256 = 2'd2,
        KeyLenBad = 2'd3
    } key_len_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StExpand,
        StDone
    } state_e;

    localparam logic [7:0] RCON_INIT = 8'h01;

    function automatic logic [3:0] nk_of(input logic [1:0] kl);
        case (kl)
            KeyLen192: return 4'd6;
            KeyLen256: return 4'd8;
            default:   return 4'd4;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] kl);
        case (kl)
            KeyLen192: return 4'd12;
            KeyLen256: return 4'd14;
            default:   return 4'd10;
        endcase
    endfunction

    function automatic logic [5:0] total_of(input logic [1:0] kl);
        case (kl)
            KeyLen192: return 6'd52;
            KeyLen256: return 6'd60;
            default:   return 6'd44;
        endcase
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] rotword(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/ks_temp_gen.sv
// Builds the temp word of the key schedule from the previous word and the external S-box.
module ks_temp_gen
    import aes_ks_pkg::*;
(
    input  logic [31:0] prev_i,
    input  logic [2:0]  j_i,
    input  logic [3:0]  nk_i,
    input  logic [7:0]  rcon_i,
    input  logic [31:0] sub_out_i,
    output logic [31:0] sub_in_o,
    output logic [31:0] temp_o
);

    always_comb begin
        sub_in_o = (j_i == 3'd0) ? rotword(prev_i) : prev_i;
        temp_o   = prev_i;
        if (j_i == 3'd0) begin
            temp_o = sub_out_i ^ {rcon_i, 24'h0};
        end else if (nk_i == 4'd8 && j_i == 3'd4) begin
            temp_o = sub_out_i;
        end
    end

endmodule

// File: rtl/key_expansion_ctrl.sv
// KeyExpansion sequencer: loads the cipher key, expands the schedule one word per cycle,
// and lends the round-key file read port to the cipher while idle.
module key_expansion_ctrl
    import aes_ks_pkg::*;
#(
    parameter int unsigned WORD_W = 32,
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned KEY_W  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        key_len,
    input  logic [KEY_W-1:0]  key_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [3:0]        nr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_sel,
    input  logic [WORD_W-1:0] rd_data,
    output logic [WORD_W-1:0] sub_in,
    input  logic [WORD_W-1:0] sub_out,
    input  logic              ext_rd_req,
    input  logic [ADDR_W-1:0] ext_rd_addr,
    output logic              ext_rd_gnt
);

    localparam int unsigned NW = KEY_W / WORD_W;

    state_e                      state_q;
    logic [ADDR_W-1:0]           i_q;
    logic [2:0]                  j_q;
    logic [WORD_W-1:0]           prev_q;
    logic [7:0]                  rcon_q;
    logic [3:0]                  nr_q;
    logic [1:0]                  kl_q;
    logic [NW-1:0][WORD_W-1:0]   key_q;
    logic                        err_q;

    logic [3:0]        nk;
    logic [5:0]        total;
    logic [2:0]        j_last;
    logic [2:0]        key_idx;
    logic [WORD_W-1:0] temp;

    assign nk      = nk_of(kl_q);
    assign total   = total_of(kl_q);
    assign j_last  = 3'(nk - 4'd1);
    // Word 0 of the left-aligned key sits in the most significant slot.
    assign key_idx = 3'(NW - 1) - i_q[2:0];

    ks_temp_gen u_temp (
        .prev_i    (prev_q),
        .j_i       (j_q),
        .nk_i      (nk),
        .rcon_i    (rcon_q),
        .sub_out_i (sub_out),
        .sub_in_o  (sub_in),
        .temp_o    (temp)
    );

    assign busy       = (state_q == StLoad) || (state_q == StExpand);
    assign done       = (state_q == StDone);
    assign err        = err_q;
    assign nr         = nr_q;
    assign wr_en      = busy;
    assign wr_addr    = i_q;
    assign rd_sel     = busy ? (i_q - {{(ADDR_W-4){1'b0}}, nk}) : ext_rd_addr;
    assign ext_rd_gnt = !busy && ext_rd_req;

    always_comb begin
        wr_data = '0;
        unique case (state_q)
            StLoad:   wr_data = key_q[key_idx];
            StExpand: wr_data = rd_data ^ temp;
            default:  wr_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            i_q     <= '0;
            j_q     <= '0;
            prev_q  <= '0;
            rcon_q  <= RCON_INIT;
            nr_q    <= '0;
            kl_q    <= '0;
            key_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        if (key_len == KeyLenBad) begin
                            err_q <= 1'b1;
                        end else begin
                            key_q   <= key_in;
                            kl_q    <= key_len;
                            nr_q    <= nr_of(key_len);
                            i_q     <= '0;
                            j_q     <= '0;
                            rcon_q  <= RCON_INIT;
                            state_q <= StLoad;
                        end
                    end
                end
                StLoad, StExpand: begin
                    prev_q <= wr_data;
                    i_q    <= i_q + 1'b1;
                    j_q    <= (j_q == j_last) ? 3'd0 : j_q + 3'd1;
                    if (state_q == StExpand && j_q == 3'd0) begin
                        rcon_q <= xtime(rcon_q);
                    end
                    if (state_q == StLoad && i_q == ADDR_W'(nk - 4'd1)) begin
                        state_q <= StExpand;
                    end
                    if (state_q == StExpand && i_q == total - 6'd1) begin
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Directed bench for key_expansion_ctrl with a behavioural register file and S-box.
module tb_key_expansion_ctrl;

    localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b,
                                     64'h0};
    localparam logic [255:0] K256 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   key_len = 2'd0;
    logic [255:0] key_in = '0;
    logic         busy, done, err, wr_en, ext_rd_gnt;
    logic [3:0]   nr;
    logic [5:0]   wr_addr, rd_sel;
    logic [31:0]  wr_data, rd_data, sub_in, sub_out;
    logic         ext_rd_req = 1'b0;
    logic [5:0]   ext_rd_addr = 6'd0;

    logic [31:0]  rf [64];
    logic [7:0]   sbox [256];
    logic         rf_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    key_expansion_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .key_len     (key_len),
        .key_in      (key_in),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .nr          (nr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .sub_in      (sub_in),
        .sub_out     (sub_out),
        .ext_rd_req  (ext_rd_req),
        .ext_rd_addr (ext_rd_addr),
        .ext_rd_gnt  (ext_rd_gnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rf_clr) begin
            for (int k = 0; k < 64; k++) rf[k] <= 32'h0;
        end else if (wr_en) begin
            rf[wr_addr] <= wr_data;
        end
    end

    assign rd_data = rf[rd_sel];
    assign sub_out = {sbox[sub_in[31:24]], sbox[sub_in[23:16]], sbox[sub_in[15:8]],
                      sbox[sub_in[7:0]]};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h0;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then the affine map.
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] b;
        if (x == 8'h00) r = 8'h00;
        else for (int k = 0; k < 254; k++) r = gmul(r, x);
        b = r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
               ^ 8'h63;
    endfunction

    task automatic clear_rf();
        @(negedge clk);
        rf_clr = 1'b1;
        @(negedge clk);
        rf_clr = 1'b0;
    endtask

    task automatic do_expand(input logic [1:0] kl, input logic [255:0] key,
                             input int pulse_at, input logic [1:0] pulse_kl,
                             output int done_n, output int writes, output int gnt_viol,
                             output int err_seen, output logic done_gnt,
                             output logic [5:0] done_rdsel, output logic post_busy,
                             output logic [31:0] first_data, output logic [5:0] first_addr);
        done_n = -1; writes = 0; gnt_viol = 0; err_seen = 0;
        done_gnt = 1'b0; done_rdsel = '0; first_data = '0; first_addr = '0;
        @(negedge clk);
        start = 1'b1; key_len = kl; key_in = key;
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 100 && done_n < 0; n++) begin
            if (n > 1) @(negedge clk);
            if (wr_en) writes++;
            if (n == 1) begin first_data = wr_data; first_addr = wr_addr; end
            if (busy && ext_rd_gnt) gnt_viol++;
            if (err) err_seen++;
            if (done) begin done_n = n; done_gnt = ext_rd_gnt; done_rdsel = rd_sel; end
            start = (n == pulse_at);
            key_len = (n == pulse_at) ? pulse_kl : kl;
        end
        @(negedge clk);
        post_busy = busy;
        if (err) err_seen++;
        start = 1'b0;
        key_len = kl;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
        checks++; if (ext_rd_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", ext_rd_gnt); end
        checks++; if (wr_addr !== 6'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        checks++; if (wr_data !== 32'h0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        checks++; if (rd_sel !== 6'd0) begin errors++; $display("FAIL reset_rd_sel got %0d want 0", rd_sel); end
        checks++; if (nr !== 4'd0) begin errors++; $display("FAIL reset_nr got %0d want 0", nr); end
        rst = 1'b0;
    endtask

    task automatic test_aes128();
        int dn, wr, gv, es; logic dg, pb; logic [5:0] dr, fa; logic [31:0] fd;
        clear_rf();
        do_expand(2'd0, K128, 0, 2'd0, dn, wr, gv, es, dg, dr, pb, fd, fa);
        checks++; if (dn != 45) begin errors++; $display("FAIL a128_done_cycle got %0d want 45", dn); end
        checks++; if (wr != 44) begin errors++; $display("FAIL a128_writes got %0d want 44", wr); end
        checks++; if (nr !== 4'd10) begin errors++; $display("FAIL a128_nr got %0d want 10", nr); end
        checks++; if (fa !== 6'd0 || fd !== 32'h2b7e1516) begin
            errors++; $display("FAIL a128_first_write got %0d/%h want 0/2b7e1516", fa, fd); end
        checks++; if (rf[4] !== 32'ha0fafe17) begin errors++; $display("FAIL a128_w4 got %h want a0fafe17", rf[4]); end
        checks++; if (rf[43] !== 32'hb6630ca6) begin errors++; $display("FAIL a128_w43 got %h want b6630ca6", rf[43]); end
        checks++; if (pb !== 1'b0) begin errors++; $display("FAIL a128_idle_after got %b want 0", pb); end
    endtask

    task automatic test_aes192();
        int dn, wr, gv, es; logic dg, pb; logic [5:0] dr, fa; logic [31:0] fd;
        clear_rf();
        do_expand(2'd1, K192, 0, 2'd0, dn, wr, gv, es, dg, dr, pb, fd, fa);
        checks++; if (dn != 53) begin errors++; $display("FAIL a192_done_cycle got %0d want 53", dn); end
        checks++; if (wr != 52) begin errors++; $display("FAIL a192_writes got %0d want 52", wr); end
        checks++; if (nr !== 4'd12) begin errors++; $display("FAIL a192_nr got %0d want 12", nr); end
        checks++; if (rf[6] !== 32'hfe0c91f7) begin errors++; $display("FAIL a192_w6 got %h want fe0c91f7", rf[6]); end
        checks++; if (rf[51] !== 32'h01002202) begin errors++; $display("FAIL a192_w51 got %h want 01002202", rf[51]); end
    endtask

    task automatic test_aes256();
        int dn, wr, gv, es; logic dg, pb; logic [5:0] dr, fa; logic [31:0] fd;
        clear_rf();
        do_expand(2'd2, K256, 0, 2'd0, dn, wr, gv, es, dg, dr, pb, fd, fa);
        checks++; if (dn != 61) begin errors++; $display("FAIL a256_done_cycle got %0d want 61", dn); end
        checks++; if (wr != 60) begin errors++; $display("FAIL a256_writes got %0d want 60", wr); end
        checks++; if (nr !== 4'd14) begin errors++; $display("FAIL a256_nr got %0d want 14", nr); end
        checks++; if (rf[8] !== 32'h9ba35411) begin errors++; $display("FAIL a256_w8 got %h want 9ba35411", rf[8]); end
        checks++; if (rf[12] !== 32'ha8b09c1a) begin errors++; $display("FAIL a256_w12 got %h want a8b09c1a", rf[12]); end
        checks++; if (rf[59] !== 32'h706c631e) begin errors++; $display("FAIL a256_w59 got %h want 706c631e", rf[59]); end
    endtask

    task automatic test_arbitration();
        int dn, wr, gv, es; logic dg, pb; logic [5:0] dr, fa; logic [31:0] fd;
        @(negedge clk);
        ext_rd_req = 1'b1; ext_rd_addr = 6'd5;
        #1;
        checks++; if (ext_rd_gnt !== 1'b1 || rd_sel !== 6'd5) begin
            errors++; $display("FAIL arb_idle got gnt=%b sel=%0d want 1/5", ext_rd_gnt, rd_sel); end
        do_expand(2'd0, K128, 0, 2'd0, dn, wr, gv, es, dg, dr, pb, fd, fa);
        checks++; if (gv != 0) begin errors++; $display("FAIL arb_busy_gnt got %0d grants want 0", gv); end
        checks++; if (dg !== 1'b1 || dr !== 6'd5) begin
            errors++; $display("FAIL arb_done_cycle got gnt=%b sel=%0d want 1/5", dg, dr); end
        checks++; if (rf[43] !== 32'hb6630ca6) begin errors++; $display("FAIL arb_w43 got %h want b6630ca6", rf[43]); end
        ext_rd_req = 1'b0; ext_rd_addr = 6'd0;
    endtask

    task automatic test_err();
        int wr = 0;
        @(negedge clk);
        start = 1'b1; key_len = 2'd3; key_in = K128;
        @(negedge clk);
        start = 1'b0; key_len = 2'd0;
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_pulse got %b want 1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL err_busy got %b want 0", busy); end
        if (wr_en) wr++;
        @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_one_cycle got %b want 0", err); end
        repeat (3) begin if (wr_en) wr++; @(negedge clk); end
        checks++; if (wr != 0) begin errors++; $display("FAIL err_no_writes got %0d want 0", wr); end
    endtask

    task automatic test_busy_start();
        int dn, wr, gv, es; logic dg, pb; logic [5:0] dr, fa; logic [31:0] fd;
        do_expand(2'd0, K128, 10, 2'd3, dn, wr, gv, es, dg, dr, pb, fd, fa);
        checks++; if (es != 0) begin errors++; $display("FAIL busy_start_err got %0d want 0", es); end
        checks++; if (dn != 45 || wr != 44) begin
            errors++; $display("FAIL busy_start_timing got %0d/%0d want 45/44", dn, wr); end
        do_expand(2'd0, K128, 45, 2'd0, dn, wr, gv, es, dg, dr, pb, fd, fa);
        checks++; if (pb !== 1'b0) begin errors++; $display("FAIL done_start_ignored got busy=%b want 0", pb); end
        checks++; if (wr != 44) begin errors++; $display("FAIL done_start_writes got %0d want 44", wr); end
    endtask

    task automatic test_reset_mid();
        int dn, wr, gv, es; logic dg, pb; logic [5:0] dr, fa; logic [31:0] fd;
        int n = 0;
        @(negedge clk);
        start = 1'b1; key_len = 2'd0; key_in = K128;
        @(negedge clk);
        start = 1'b0;
        while (!(wr_en && wr_addr == 6'd20) && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL midrst_reach_i20 got timeout want i=20"); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (wr_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_abort got wr_en=%b busy=%b want 0/0", wr_en, busy); end
        rst = 1'b0;
        clear_rf();
        do_expand(2'd0, K128, 0, 2'd0, dn, wr, gv, es, dg, dr, pb, fd, fa);
        checks++; if (dn != 45 || wr != 44) begin
            errors++; $display("FAIL midrst_rerun got %0d/%0d want 45/44", dn, wr); end
        checks++; if (rf[4] !== 32'ha0fafe17) begin errors++; $display("FAIL midrst_w4 got %h want a0fafe17", rf[4]); end
        checks++; if (rf[43] !== 32'hb6630ca6) begin errors++; $display("FAIL midrst_w43 got %h want b6630ca6", rf[43]); end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) sbox[k] = sbox_calc(8'(k));
        for (int k = 0; k < 64; k++) rf[k] = 32'h0;
        test_reset();
        test_aes128();
        test_aes192();
        test_aes256();
        test_arbitration();
        test_err();
        test_busy_start();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
